// File: rtl/mf_cegen_pkg.sv
// ---------------------------------------------------------------------------
// mf_cegen_pkg
// Shared types and widths for the multi-channel clock-enable generator.
//   cegenState_t   : sequencing states of the generator
//   CH_IDX_W       : width of the configuration channel index
//   DEFAULT_DIV_W  : default width of the divisor / phase fields
//   divCntW()      : channel counter width for a given divisor width
//   settleCntW()   : width of the run-in counter for a given settle length
// ---------------------------------------------------------------------------
package mf_cegen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_RUN    = 2'd3
   } cegenState_t;

   localparam int CH_IDX_W      = 3;
   localparam int DEFAULT_DIV_W = 8;

   // A counter only ever holds 0..D-1 and D fits in the divisor field,
   // so the counter can share the divisor width.
   function automatic int divCntW(input int divW);
      return divW;
   endfunction

   // The run-in counter must reach settleCyc-1; keep at least one bit.
   function automatic int settleCntW(input int settleCyc);
      return (settleCyc < 2) ? 1 : $clog2(settleCyc);
   endfunction

endpackage

// File: rtl/mf_cegen_multi_if.sv
// ---------------------------------------------------------------------------
// mf_cegen_multi_if
// Configuration handshake bundle for mf_cegen_multi.
//   cfg_valid  : requester has a configuration word
//   cfg_ready  : generator can accept a word this cycle
//   cfg_ch     : target channel index
//   cfg_div    : divisor D (0 disables the channel)
//   cfg_phase  : phase P of the strobe within the period
//   cfg_err    : one-cycle pulse after an out-of-range channel was accepted
// master drives the request side, slave is the generator.
// ---------------------------------------------------------------------------
interface mf_cegen_multi_if #(
   parameter int DIV_W = 8
);
   import mf_cegen_pkg::*;

   logic                cfg_valid;
   logic                cfg_ready;
   logic [CH_IDX_W-1:0] cfg_ch;
   logic [DIV_W-1:0]    cfg_div;
   logic [DIV_W-1:0]    cfg_phase;
   logic                cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_div, cfg_phase,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div, cfg_phase,
      output cfg_ready, cfg_err
   );

endinterface

// File: rtl/mf_cegen_chan.sv
// ---------------------------------------------------------------------------
// mf_cegen_chan
// One clock-enable channel: free-running modulo-D counter, phase compare,
// registered enable strobe and registered square-wave level.
//   i_refclk     : clock
//   i_rst        : synchronous active-high reset
//   i_div        : divisor D (0 = channel disabled)
//   i_phase      : requested phase P (clamped to D-1)
//   i_advance    : generator is in SETTLE or RUN this cycle
//   i_runNext    : generator will be in RUN next cycle
//   i_activeNext : generator will be in SETTLE or RUN next cycle
//   o_ce         : one-cycle enable strobe
//   o_clkLvl     : square-wave level, high for ceil(D/2) of every D cycles
// ---------------------------------------------------------------------------
module mf_cegen_chan #(
   parameter int DIV_W = 8
) (
   input  logic             i_refclk,
   input  logic             i_rst,
   input  logic [DIV_W-1:0] i_div,
   input  logic [DIV_W-1:0] i_phase,
   input  logic             i_advance,
   input  logic             i_runNext,
   input  logic             i_activeNext,
   output logic             o_ce,
   output logic             o_clkLvl
);

   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] w_pe;
   logic [DIV_W-1:0] w_half;
   logic [DIV_W-1:0] w_offs;
   logic             w_en;
   logic             w_last;

   // Derive the clamped phase, the high-time of the square wave and the
   // distance of the counter past the phase point.  The offset is taken
   // modulo D: when the counter is below the phase the subtraction wraps
   // and adding D brings it back into 0..D-1 within DIV_W bits.
   always_comb begin
      w_en   = (i_div != '0);
      w_pe   = (i_phase < i_div) ? i_phase : i_div - DIV_W'(1);
      w_half = (i_div >> 1) + DIV_W'(i_div[0]);
      w_offs = r_cnt - w_pe;
      if (r_cnt < w_pe) begin
         w_offs = w_offs + i_div;
      end
      w_last = (r_cnt >= i_div - DIV_W'(1));
   end

   // The counter sits at zero whenever the generator is not running, so
   // leaving ALIGN restarts every channel from the same point.  Strobe
   // and level look at the next state so they can never outlive RUN or
   // SETTLE; the level additionally needs a live counter this cycle,
   // which rules out the stale value held during ALIGN.
   always_ff @(posedge i_refclk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         o_ce     <= 1'b0;
         o_clkLvl <= 1'b0;
      end else begin
         if (!w_en || !i_advance) begin
            r_cnt <= '0;
         end else if (w_last) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + DIV_W'(1);
         end
         o_ce     <= i_runNext && w_en && (r_cnt == w_pe);
         o_clkLvl <= i_activeNext && i_advance && w_en && (w_offs < w_half);
      end
   end

endmodule

// File: rtl/mf_cegen_multi.sv
// ---------------------------------------------------------------------------
// mf_cegen_multi
// Multi-channel clock-enable generator.  Waits for the upstream PLL,
// realigns all channel counters, runs them in for SETTLE_CYC cycles and
// then reports lock while emitting per-channel strobes and levels.
// Any accepted reconfiguration while settling or running realigns.
//   refclk     : the only clock
//   rst        : synchronous active-high reset
//   src_locked : upstream PLL lock, synchronous to refclk
//   cfg        : configuration handshake (slave side)
//   ce         : per-channel one-cycle enable strobes
//   clk_lvl    : per-channel square-wave levels
//   locked     : high while in RUN
// ---------------------------------------------------------------------------
module mf_cegen_multi
   import mf_cegen_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DIV_W      = DEFAULT_DIV_W,
   parameter int SETTLE_CYC = 16
) (
   input  logic                 refclk,
   input  logic                 rst,
   input  logic                 src_locked,
   mf_cegen_multi_if.slave      cfg,
   output logic [NUM_CH-1:0]    ce,
   output logic [NUM_CH-1:0]    clk_lvl,
   output logic                 locked
);

   localparam int SETTLE_CNT_W = settleCntW(SETTLE_CYC);
   localparam int CNT_W        = divCntW(DIV_W);

   cegenState_t              r_state;
   cegenState_t              w_nextState;
   logic [SETTLE_CNT_W-1:0]  r_settleCnt;
   logic [DIV_W-1:0]         r_div   [NUM_CH];
   logic [DIV_W-1:0]         r_phase [NUM_CH];
   logic                     r_cfgReady;
   logic                     r_cfgErr;
   logic                     w_xfer;
   logic                     w_chOk;
   logic                     w_goodXfer;
   logic                     w_settleDone;
   logic                     w_advance;
   logic                     w_runNext;
   logic                     w_activeNext;

   // Handshake decode: a transfer is any valid seen while ready, and it
   // only targets a real channel when the index is below NUM_CH.
   always_comb begin
      w_xfer       = cfg.cfg_valid && r_cfgReady;
      w_chOk       = (32'(cfg.cfg_ch) < NUM_CH);
      w_goodXfer   = w_xfer && w_chOk;
      w_settleDone = (r_settleCnt == SETTLE_CNT_W'(SETTLE_CYC - 1));
   end

   // Next-state decode.  Losing the upstream lock beats everything else;
   // a good reconfiguration while settling or running forces a realign.
   always_comb begin
      w_nextState = r_state;
      if (!src_locked) begin
         w_nextState = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:   w_nextState = ST_ALIGN;
            ST_ALIGN:  w_nextState = ST_SETTLE;
            ST_SETTLE: begin
               if (w_goodXfer) begin
                  w_nextState = ST_ALIGN;
               end else if (w_settleDone) begin
                  w_nextState = ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_goodXfer) begin
                  w_nextState = ST_ALIGN;
               end
            end
            default:   w_nextState = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge refclk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Run-in counter: counts cycles spent in SETTLE and restarts whenever
   // SETTLE is entered afresh or left.
   always_ff @(posedge refclk) begin
      if (rst) begin
         r_settleCnt <= '0;
      end else if (r_state == ST_SETTLE && w_nextState == ST_SETTLE) begin
         r_settleCnt <= r_settleCnt + SETTLE_CNT_W'(1);
      end else begin
         r_settleCnt <= '0;
      end
   end

   // Ready is registered from the next state so it is low exactly during
   // ALIGN and also held low while reset is applied.  The error pulse
   // flags an accepted word that addressed a non-existent channel.
   always_ff @(posedge refclk) begin
      if (rst) begin
         r_cfgReady <= 1'b0;
         r_cfgErr   <= 1'b0;
      end else begin
         r_cfgReady <= (w_nextState != ST_ALIGN);
         r_cfgErr   <= w_xfer && !w_chOk;
      end
   end

   // Shadow registers are written by any good transfer, even when the
   // upstream lock is dropping in the same cycle.
   always_ff @(posedge refclk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_div[i]   <= '0;
            r_phase[i] <= '0;
         end
      end else if (w_goodXfer) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_IDX_W'(i)) begin
               r_div[i]   <= cfg.cfg_div;
               r_phase[i] <= cfg.cfg_phase;
            end
         end
      end
   end

   assign w_advance    = (r_state == ST_SETTLE) || (r_state == ST_RUN);
   assign w_runNext    = (w_nextState == ST_RUN);
   assign w_activeNext = (w_nextState == ST_SETTLE) || (w_nextState == ST_RUN);

   assign cfg.cfg_ready = r_cfgReady;
   assign cfg.cfg_err   = r_cfgErr;
   assign locked        = (r_state == ST_RUN);

   // One channel engine per output bit.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      mf_cegen_chan #(
         .DIV_W (CNT_W)
      ) u_chan (
         .i_refclk     (refclk),
         .i_rst        (rst),
         .i_div        (r_div[gi]),
         .i_phase      (r_phase[gi]),
         .i_advance    (w_advance),
         .i_runNext    (w_runNext),
         .i_activeNext (w_activeNext),
         .o_ce         (ce[gi]),
         .o_clkLvl     (clk_lvl[gi])
      );
   end

endmodule

// File: tb/tb_mf_cegen_multi.sv
// ---------------------------------------------------------------------------
// tb_mf_cegen_multi
// Self-checking bench for mf_cegen_multi: directed lock-up, divide/phase,
// reconfiguration, bad-index, lock-loss and reset scenarios, then a
// randomized stretch, all compared every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_mf_cegen_multi;

   localparam int NUM_CH     = 4;
   localparam int DIV_W      = 8;
   localparam int SETTLE_CYC = 16;

   typedef enum int {M_IDLE, M_ALIGN, M_SETTLE, M_RUN} modelState_t;

   logic              refclk = 1'b0;
   logic              rst;
   logic              src_locked;
   logic [NUM_CH-1:0] ce;
   logic [NUM_CH-1:0] clk_lvl;
   logic              locked;

   int errors = 0;
   int checks = 0;

   // Behavioural model: state, position since the first SETTLE cycle,
   // shadow configuration and expected registered outputs.
   modelState_t       mState = M_IDLE;
   int                mPos   = 0;
   int                mDiv   [NUM_CH];
   int                mPhase [NUM_CH];
   logic              mReady = 1'b0;
   logic              mErr   = 1'b0;
   logic [NUM_CH-1:0] mCe    = '0;
   logic [NUM_CH-1:0] mLvl   = '0;

   mf_cegen_multi_if #(.DIV_W(DIV_W)) cfgIf ();

   mf_cegen_multi #(
      .NUM_CH     (NUM_CH),
      .DIV_W      (DIV_W),
      .SETTLE_CYC (SETTLE_CYC)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .src_locked (src_locked),
      .cfg        (cfgIf),
      .ce         (ce),
      .clk_lvl    (clk_lvl),
      .locked     (locked)
   );

   always #5 refclk = ~refclk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit v, input int ch, input int d, input int p);
      cfgIf.cfg_valid = v;
      cfgIf.cfg_ch    = ch[2:0];
      cfgIf.cfg_div   = d[DIV_W-1:0];
      cfgIf.cfg_phase = p[DIV_W-1:0];
   endtask

   // Advance the model by one rising edge using the inputs the DUT sees.
   task automatic modelEdge();
      modelState_t ns;
      bit          oldActive;
      bit          nsActive;
      bit          xfer;
      bit          good;
      int          chIdx;
      int          d;
      int          pe;
      if (rst) begin
         mState = M_IDLE;
         mPos   = 0;
         mReady = 1'b0;
         mErr   = 1'b0;
         mCe    = '0;
         mLvl   = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            mDiv[i]   = 0;
            mPhase[i] = 0;
         end
         return;
      end
      oldActive = (mState == M_SETTLE) || (mState == M_RUN);
      xfer      = cfgIf.cfg_valid && mReady;
      chIdx     = int'(cfgIf.cfg_ch);
      good      = xfer && (chIdx < NUM_CH);
      ns        = mState;
      if (!src_locked) ns = M_IDLE;
      else if (mState == M_IDLE) ns = M_ALIGN;
      else if (mState == M_ALIGN) ns = M_SETTLE;
      else if (good) ns = M_ALIGN;
      else if (mState == M_SETTLE && mPos == SETTLE_CYC - 1) ns = M_RUN;
      nsActive = (ns == M_SETTLE) || (ns == M_RUN);
      for (int i = 0; i < NUM_CH; i++) begin
         d  = mDiv[i];
         pe = (mPhase[i] < d) ? mPhase[i] : d - 1;
         mCe[i]  = (ns == M_RUN) && oldActive && (d > 0) && ((mPos % d) == pe);
         mLvl[i] = nsActive && oldActive && (d > 0) && (((mPos - pe + d) % d) < (d + 1) / 2);
      end
      if (mState == M_ALIGN) mPos = 0;
      else if (oldActive) mPos = mPos + 1;
      else mPos = 0;
      mErr = xfer && (chIdx >= NUM_CH);
      if (good) begin
         mDiv[chIdx]   = int'(cfgIf.cfg_div);
         mPhase[chIdx] = int'(cfgIf.cfg_phase);
      end
      mReady = (ns != M_ALIGN);
      mState = ns;
   endtask

   task automatic checkOutput();
      checkVal("ce",        32'(ce),            32'(mCe));
      checkVal("clk_lvl",   32'(clk_lvl),       32'(mLvl));
      checkVal("locked",    32'(locked),        32'(mState == M_RUN));
      checkVal("cfg_ready", 32'(cfgIf.cfg_ready), 32'(mReady));
      checkVal("cfg_err",   32'(cfgIf.cfg_err),   32'(mErr));
   endtask

   task automatic tick();
      @(posedge refclk);
      modelEdge();
      #1;
      checkOutput();
   endtask

   task automatic cfgWrite(input int ch, input int d, input int p);
      applyStimulus(1'b1, ch, d, p);
      tick();
      applyStimulus(1'b0, 0, 0, 0);
   endtask

   initial begin
      bit found;
      int dropLeft;
      rst        = 1'b1;
      src_locked = 1'b0;
      applyStimulus(1'b0, 0, 0, 0);
      repeat (2) tick();
      checkVal("rst_ce",     32'(ce),              32'd0);
      checkVal("rst_locked", 32'(locked),          32'd0);
      checkVal("rst_ready",  32'(cfgIf.cfg_ready), 32'd0);

      rst = 1'b0;
      tick();
      checkVal("ready_after_rst", 32'(cfgIf.cfg_ready), 32'd1);

      $display("[TB] configuring channels in IDLE");
      cfgWrite(0, 4, 1);
      cfgWrite(1, 16, 0);
      cfgWrite(2, 0, 0);
      cfgWrite(3, 1, 0);

      $display("[TB] lock-up sequence");
      src_locked = 1'b1;
      tick();
      checkVal("align_ready", 32'(cfgIf.cfg_ready), 32'd0);
      tick();
      checkVal("settle_ready", 32'(cfgIf.cfg_ready), 32'd1);
      repeat (SETTLE_CYC - 1) tick();
      checkVal("pre_lock", 32'(locked), 32'd0);
      tick();
      checkVal("lock_at_2_plus_settle", 32'(locked), 32'd1);

      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         tick();
         if (ce[1]) found = 1'b1;
      end
      checkVal("ce1_seen", 32'(found), 32'd1);
      tick();
      checkVal("ce0_behind_ce1", 32'(ce[0]), 32'd1);
      checkVal("ce1_gap",        32'(ce[1]), 32'd0);
      checkVal("lvl0_at_ce0",    32'(clk_lvl[0]), 32'd1);
      repeat (4) tick();
      checkVal("ce0_period4", 32'(ce[0]), 32'd1);
      repeat (10) tick();

      $display("[TB] out-of-range channel");
      cfgWrite(7, 3, 3);
      checkVal("bad_err",    32'(cfgIf.cfg_err), 32'd1);
      checkVal("bad_locked", 32'(locked),        32'd1);
      tick();

      $display("[TB] reconfigure in RUN");
      cfgWrite(2, 5, 0);
      checkVal("reconf_unlock", 32'(locked),          32'd0);
      checkVal("reconf_align",  32'(cfgIf.cfg_ready), 32'd0);
      repeat (SETTLE_CYC) tick();
      checkVal("reconf_prelock", 32'(locked), 32'd0);
      tick();
      checkVal("reconf_relock", 32'(locked), 32'd1);
      repeat (12) tick();

      $display("[TB] phase clamp D=3 P=9");
      cfgWrite(2, 3, 9);
      repeat (SETTLE_CYC + 14) tick();

      $display("[TB] randomized stretch");
      dropLeft = 0;
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 149) == 0);
         if (dropLeft > 0) begin
            src_locked = 1'b0;
            dropLeft--;
         end else if ($urandom_range(0, 59) == 0) begin
            src_locked = 1'b0;
            dropLeft   = int'($urandom_range(0, 2));
         end else begin
            src_locked = 1'b1;
         end
         if ($urandom_range(0, 24) == 0) begin
            applyStimulus(1'b1, int'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12)),
                          int'($urandom_range(0, 15)));
         end else begin
            applyStimulus(1'b0, 0, 0, 0);
         end
         tick();
      end

      $display("[TB] restore known configuration");
      rst        = 1'b0;
      src_locked = 1'b1;
      applyStimulus(1'b0, 0, 0, 0);
      tick();
      tick();
      cfgWrite(0, 4, 1);
      tick();
      cfgWrite(1, 16, 0);
      tick();
      cfgWrite(2, 0, 0);
      tick();
      cfgWrite(3, 1, 0);
      repeat (SETTLE_CYC + 1) tick();
      checkVal("restore_lock", 32'(locked), 32'd1);
      for (int k = 0; k < 6; k++) begin
         tick();
         checkVal("d1_ce_every_cycle", 32'(ce[3]),      32'd1);
         checkVal("d1_lvl_high",       32'(clk_lvl[3]), 32'd1);
         checkVal("d0_ce_quiet",       32'(ce[2]),      32'd0);
      end

      $display("[TB] lock loss in RUN");
      src_locked = 1'b0;
      tick();
      checkVal("loss_ce",     32'(ce),     32'd0);
      checkVal("loss_locked", 32'(locked), 32'd0);
      src_locked = 1'b1;
      repeat (2 + SETTLE_CYC) tick();
      checkVal("loss_relock", 32'(locked), 32'd1);
      repeat (5) tick();

      $display("[TB] reset pulse in RUN");
      rst = 1'b1;
      tick();
      checkVal("rstrun_ce",     32'(ce),            32'd0);
      checkVal("rstrun_lvl",    32'(clk_lvl),       32'd0);
      checkVal("rstrun_locked", 32'(locked),        32'd0);
      checkVal("rstrun_err",    32'(cfgIf.cfg_err), 32'd0);
      rst = 1'b0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mf_cegen_multi.md
MF_CEGEN_MULTI -- requirements
Module: mf_cegen_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of clock-enable channels, 1..8.
REQ-002 SHALL have parameter DIV_W, default 8: width of the divisor and phase fields.
REQ-003 SHALL have parameter SETTLE_CYC, default 16: number of run-in cycles before locked asserts, at least 1.
REQ-004 SHALL have port refclk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port src_locked, input, 1 bit: upstream PLL lock, already synchronous to refclk.
REQ-007 SHALL have ports cfg_valid (input, 1) and cfg_ready (output, 1): configuration handshake.
REQ-008 SHALL have port cfg_ch, input, 3 bits: target channel index.
REQ-009 SHALL have ports cfg_div and cfg_phase, input, DIV_W each: divisor D and phase P.
REQ-010 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when cfg_ch >= NUM_CH is accepted.
REQ-011 SHALL have port ce, output, NUM_CH bits: one-cycle enable strobe per channel.
REQ-012 SHALL have port clk_lvl, output, NUM_CH bits: square-wave level per channel.
REQ-013 SHALL have port locked, output, 1 bit: high only in state RUN.

Function
REQ-014 SHALL implement states IDLE, ALIGN, SETTLE and RUN.
REQ-015 SHALL move IDLE->ALIGN when src_locked=1; ALIGN->SETTLE after exactly 1 cycle; SETTLE->RUN after SETTLE_CYC cycles.
REQ-016 SHALL go to IDLE from any state on the cycle after src_locked=0; src_locked=0 takes priority over every other transition.
REQ-017 SHALL drive cfg_ready=1 in every state except ALIGN; a transfer occurs when cfg_valid and cfg_ready are both 1.
REQ-018 SHALL write an accepted transfer into the channel's shadow div/phase registers; cfg_ch >= NUM_CH writes nothing and pulses cfg_err on the following cycle.
REQ-019 SHALL, on a valid accepted transfer in SETTLE or RUN, go to ALIGN on the next cycle and drop locked in that same cycle.
REQ-020 SHALL, in ALIGN, load every channel counter with 0 so that all channels restart coherently.
REQ-021 SHALL, in SETTLE and RUN, advance each counter 0..D-1 and wrap to 0.
REQ-022 SHALL treat D=0 as a disabled channel: counter held at 0, ce=0, clk_lvl=0.
REQ-023 SHALL use an effective phase Pe equal to P when P < D, otherwise D-1.
REQ-024 SHALL register ce[i], asserting it the cycle after cnt==Pe, and only while the state is RUN.
REQ-025 SHALL set clk_lvl[i]=1 when ((cnt-Pe) mod D) < ceil(D/2); it is registered and forced to 0 outside SETTLE and RUN.
REQ-026 SHALL, for D=1, drive ce[i]=1 on every RUN cycle and clk_lvl[i]=1 constantly.
REQ-027 SHALL treat src_locked=0 together with a cfg transfer as follows: the shadow register is written and the state goes to IDLE.

Reset
REQ-028 SHALL, on rst=1, set state to IDLE, clear all shadow divisors and phases to 0, clear counters, and drive ce=0, clk_lvl=0, locked=0 and cfg_err=0 on the next edge.
REQ-029 SHALL drive cfg_ready=1 one cycle after rst releases.
REQ-030 SHALL, if rst asserts mid-SETTLE or mid-RUN, abandon that operation with no residual strobe.

Structure
REQ-031 SHALL place the state enum, the channel-index width and the DIV_W-dependent widths in the shared package mf_cegen_pkg.
REQ-032 SHALL implement each channel's counter, phase compare, ce and clk_lvl logic in the sub-module mf_cegen_chan, instantiated NUM_CH times by a generate loop.

Verification
REQ-033 SHALL cover lock-up: rst, then src_locked=1 at cycle 0 -> ALIGN at cycle 1, SETTLE at cycle 2, locked=1 at cycle 2+SETTLE_CYC.
REQ-034 SHALL cover divide and phase: ch0 with D=4, P=1 and ch1 with D=16, P=0 in RUN -> ce0 period 4, ce1 period 16, ce0 one cycle behind ce1 at alignment, clk_lvl0 pattern 1100 shifted by 1.
REQ-035 SHALL cover reconfiguration: write ch2 D=5 during RUN -> locked=0 the next cycle, ALIGN, and relock after SETTLE_CYC+1 cycles with all channels realigned.
REQ-036 SHALL cover bad input: cfg_ch=7 with NUM_CH=4 -> cfg_err pulse, state unchanged; D=3 with P=9 -> Pe=2.
REQ-037 SHALL cover lock loss: src_locked falls in RUN -> IDLE, ce=0 and locked=0 the next cycle; D=0 channel -> ce stays 0 throughout.
REQ-038 SHALL cover D=1 -> ce=1 on every RUN cycle; rst pulse in RUN -> all outputs 0 the next cycle.
